// File: rtl/ntt_ctrl_pkg.sv
// Shared types, opcodes and the per-issue address generator for the NTT sequencer.
package ntt_ctrl_pkg;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    localparam logic [1:0] OP_NTT  = 2'b00;
    localparam logic [1:0] OP_INTT = 2'b01;
    localparam logic [1:0] OP_PWM  = 2'b10;

    localparam int unsigned N                = 256;
    localparam int unsigned NUM_LAYERS       = 7;
    localparam int unsigned ISSUES_PER_LAYER = 128;
    localparam int unsigned AddrW            = $clog2(N);

    typedef struct packed {
        logic [AddrW-1:0] addr_a;
        logic [AddrW-1:0] addr_b;
        logic [6:0]       zeta;
    } addr_t;

    // Butterfly pair and twiddle index for issue number cnt within a layer.
    function automatic addr_t calc_addr(input logic [1:0] op, input logic [2:0] layer,
                                        input logic [6:0] cnt);
        addr_t      r;
        logic [3:0] lg;
        logic [7:0] len;
        logic [6:0] g;
        logic [7:0] j;
        r  = '0;
        lg = 4'd7 - {1'b0, layer};
        if (op == OP_INTT) begin
            lg = {1'b0, layer} + 4'd1;
        end
        len = 8'd1 << lg;
        g   = cnt >> lg;
        j   = ({1'b0, g} << (lg + 4'd1)) | ({1'b0, cnt} & (len - 8'd1));
        r.addr_a = j;
        r.addr_b = j + len;
        if (op == OP_INTT) begin
            r.zeta = (7'd127 >> layer) - g;
        end else begin
            r.zeta = (7'd1 << layer) + g;
        end
        if (op == OP_PWM) begin
            r.addr_a = {cnt, 1'b0};
            r.addr_b = {cnt, 1'b1};
            r.zeta   = 7'd64 + {1'b0, cnt[6:1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_addr_fifo.sv
// Synchronous tag FIFO holding the write-back address pair of each in-flight butterfly.
module ntt_addr_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] DepthC = Depth[PtrW:0];

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (cnt_q != DepthC);
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/ntt_ctrl.sv
// Sequencer driving a 256-point NTT/INTT through one pipelined butterfly, layer by layer.
// Define NTT_CTRL_PWM_EN to enable the single-pass pointwise-multiply mode (mode 10).
module ntt_ctrl
    import ntt_ctrl_pkg::*;
#(
    parameter int unsigned BF_LATENCY = 7,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             rd_en_o,
    output logic [AddrW-1:0] rd_addr_a_o,
    output logic [AddrW-1:0] rd_addr_b_o,
    output logic [6:0]       zeta_addr_o,
    output logic             bf_valid_o,
    output logic [1:0]       bf_op_o,
    input  logic             bf_valid_out_i,
    output logic             wr_en_o,
    output logic [AddrW-1:0] wr_addr_a_o,
    output logic [AddrW-1:0] wr_addr_b_o
);

    // Never let the tag FIFO be shallower than the pipeline can fill.
    localparam int unsigned FifoDepth =
        (FIFO_DEPTH < BF_LATENCY + 2) ? 2 ** $clog2(BF_LATENCY + 2) : FIFO_DEPTH;
    localparam logic [6:0] LastCnt   = 7'(ISSUES_PER_LAYER - 1);
    localparam logic [2:0] LastLayer = 3'(NUM_LAYERS - 1);

    state_e     state_q, state_d;
    logic [2:0] layer_q, layer_d;
    logic [6:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic       bf_valid_q;
    logic       err_q, err_d;

    logic                     mode_legal, start_ok, last_layer, rd_en, done;
    logic                     fifo_empty, wr_en;
    logic [$clog2(FifoDepth):0] fifo_count;
    logic [2*AddrW-1:0]       fifo_rdata;
    addr_t                    addr;

`ifdef NTT_CTRL_PWM_EN
    assign mode_legal = (mode_i != 2'b11);
`else
    assign mode_legal = (mode_i == OP_NTT) || (mode_i == OP_INTT);
`endif

    assign start_ok   = (state_q == StIdle) && start_i && mode_legal;
    assign last_layer = (op_q == OP_PWM) || (layer_q == LastLayer);
    assign addr       = calc_addr(op_q, layer_q, cnt_q);

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_en   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StIssue;
                    layer_d = '0;
                    cnt_d   = '0;
                    op_d    = mode_i;
                end
            end
            StIssue: begin
                rd_en = 1'b1;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == LastCnt) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Next layer reads may only start once every write of this one has landed.
                if (fifo_count == '0) begin
                    if (last_layer) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                        layer_d = layer_q + 3'd1;
                        cnt_d   = '0;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign wr_en = bf_valid_out_i && !fifo_empty;
    assign err_d = err_q || (bf_valid_out_i && fifo_empty);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            layer_q    <= '0;
            cnt_q      <= '0;
            op_q       <= OP_NTT;
            bf_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            bf_valid_q <= rd_en;
            err_q      <= err_d;
        end
    end

    ntt_addr_fifo #(
        .Width (2 * AddrW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (start_ok),
        .push_i  (rd_en),
        .wdata_i ({addr.addr_a, addr.addr_b}),
        .pop_i   (wr_en),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign busy_o      = (state_q != StIdle);
    assign done_o      = done;
    assign err_o       = err_q;
    assign rd_en_o     = rd_en;
    assign rd_addr_a_o = rd_en ? addr.addr_a : '0;
    assign rd_addr_b_o = rd_en ? addr.addr_b : '0;
    assign zeta_addr_o = rd_en ? addr.zeta : '0;
    assign bf_valid_o  = bf_valid_q;
    assign bf_op_o     = op_q;
    assign wr_en_o     = wr_en;
    assign wr_addr_a_o = wr_en ? fifo_rdata[2*AddrW-1:AddrW] : '0;
    assign wr_addr_b_o = wr_en ? fifo_rdata[AddrW-1:0] : '0;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Scoreboard bench for ntt_ctrl: reference issue order from the textbook Kyber loops,
// behavioural 7-cycle butterfly, write-back matched against the issued pairs.
module tb_ntt_ctrl;

    localparam int Lat = 7;

    logic       clk = 1'b0;
    logic       reset, start, inj;
    logic [1:0] mode;
    logic       busy, done, err, rd_en, bf_valid, wr_en, bf_valid_out;
    logic [7:0] rd_a, rd_b, wr_a, wr_b;
    logic [6:0] zeta;
    logic [1:0] bf_op;
    logic [Lat-1:0] pipe = '0;

    always #5 clk = ~clk;

    // Behavioural butterfly: only the valid strobe matters to the sequencer.
    always @(posedge clk) pipe <= {pipe[Lat-2:0], (bf_valid === 1'b1)};
    assign bf_valid_out = pipe[Lat-1] | inj;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_ctrl #(
        .BF_LATENCY (Lat),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start),
        .mode_i         (mode),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .rd_en_o        (rd_en),
        .rd_addr_a_o    (rd_a),
        .rd_addr_b_o    (rd_b),
        .zeta_addr_o    (zeta),
        .bf_valid_o     (bf_valid),
        .bf_op_o        (bf_op),
        .bf_valid_out_i (bf_valid_out),
        .wr_en_o        (wr_en),
        .wr_addr_a_o    (wr_a),
        .wr_addr_b_o    (wr_b)
    );

    logic [24:0] exp_q[$];
    logic [15:0] wr_q[$];
    int n_checks = 0, n_fail = 0;
    int n_writes = 0, busy_cycles = 0, done_cnt = 0, done_first = -1, done_last = -1, t0 = 0;
    logic rd_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (rel cycle %0d)", tag, got, exp, cyc - t0);
        end
    endtask

    function automatic logic [24:0] pk(input int a, input int b, input int z, input int op);
        return {a[7:0], b[7:0], z[6:0], op[1:0]};
    endfunction

    function automatic logic [63:0] all_outs();
        return {17'b0, busy, done, err, rd_en, rd_a, rd_b, zeta, bf_valid, bf_op, wr_en,
                wr_a, wr_b};
    endfunction

    task automatic load_exp(input logic [1:0] m);
        int k;
        if (m == 2'b00) begin
            k = 1;
            for (int len = 128; len >= 2; len = len / 2) begin
                for (int s = 0; s < 256; s += 2 * len) begin
                    for (int j = s; j < s + len; j++) exp_q.push_back(pk(j, j + len, k, 0));
                    k++;
                end
            end
        end else if (m == 2'b01) begin
            k = 127;
            for (int len = 2; len <= 128; len = len * 2) begin
                for (int s = 0; s < 256; s += 2 * len) begin
                    for (int j = s; j < s + len; j++) exp_q.push_back(pk(j, j + len, k, 1));
                    k--;
                end
            end
        end else begin
            for (int i = 0; i < 128; i++) exp_q.push_back(pk(2 * i, 2 * i + 1, 64 + i / 2, 2));
        end
    endtask

    always @(negedge clk) begin
        logic [24:0] e;
        if (reset) begin
            rd_prev = 1'b0;
        end else begin
            check_eq("bf_valid_delay", 64'(bf_valid), 64'(rd_prev));
            rd_prev = rd_en;
            if (rd_en) begin
                if (exp_q.size() == 0) begin
                    check_eq("rd_unexpected_issue_qsize", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rd_issue", 64'({rd_a, rd_b, zeta, bf_op}), 64'(e));
                    wr_q.push_back(e[24:9]);
                end
            end
            if (wr_en) begin
                n_writes++;
                if (wr_q.size() == 0) begin
                    check_eq("wr_unexpected_qsize", 0, 1);
                end else begin
                    check_eq("wr_pair", 64'({wr_a, wr_b}), 64'(wr_q.pop_front()));
                end
            end
            if (done) begin
                if (done_cnt == 0) done_first = cyc - t0;
                done_last = cyc - t0;
                done_cnt++;
            end
            if (busy) busy_cycles++;
        end
    end

    task automatic clear_stats();
        n_writes = 0;
        busy_cycles = 0;
        done_cnt = 0;
        done_first = -1;
        done_last = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        wr_q.delete();
    endtask

    task automatic run(input logic [1:0] m, input int exp_done, input int exp_wr,
                       input bit pulses, input logic exp_err);
        load_exp(m);
        clear_stats();
        @(posedge clk);
        #1;
        mode = m;
        start = 1'b1;
        t0 = cyc;
        while (done_cnt == 0 && cyc - t0 < 3000) begin
            @(posedge clk);
            #1;
            start = pulses && (cyc - t0 == 50 || cyc - t0 == 500);
        end
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("done_cycle", 64'(done_first), 64'(exp_done));
        check_eq("done_count", 64'(done_cnt), 1);
        check_eq("busy_cycles", 64'(busy_cycles), 64'(exp_done));
        check_eq("write_count", 64'(n_writes), 64'(exp_wr));
        check_eq("issues_left", 64'(exp_q.size()), 0);
        check_eq("writes_left", 64'(wr_q.size()), 0);
        check_eq("idle_after_run", 64'(busy), 0);
        check_eq("err_after_run", 64'(err), 64'(exp_err));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 2'b00;
        inj   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", all_outs(), 0);
        reset = 1'b0;

        // NTT with stray start pulses at cycles 50 and 500, then INTT.
        run(2'b00, 960, 896, 1'b1, 1'b0);
        run(2'b01, 960, 896, 1'b0, 1'b0);

        // start held high: second run begins one cycle after IDLE returns.
        load_exp(2'b00);
        load_exp(2'b00);
        clear_stats();
        @(posedge clk);
        #1;
        mode = 2'b00;
        start = 1'b1;
        t0 = cyc;
        while (done_cnt < 2 && cyc - t0 < 5000) begin
            @(posedge clk);
            #1;
            if (cyc - t0 == 961) check_eq("held_idle_961", 64'(busy), 0);
            if (cyc - t0 == 962) begin
                check_eq("held_busy_962", 64'(busy), 1);
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("held_done_first", 64'(done_first), 960);
        check_eq("held_done_last", 64'(done_last), 1921);
        check_eq("held_done_count", 64'(done_cnt), 2);
        check_eq("held_writes", 64'(n_writes), 1792);
        check_eq("held_busy_cycles", 64'(busy_cycles), 1920);
        check_eq("held_issues_left", 64'(exp_q.size()), 0);

        // Reset in the middle of layer 3.
        load_exp(2'b00);
        clear_stats();
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = cyc;
        while (cyc - t0 < 450) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        wr_q.delete();
        check_eq("midreset_outputs", all_outs(), 0);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            check_eq("midreset_no_write", 64'(wr_en), 0);
        end
        check_eq("midreset_err", 64'(err), 1);
        check_eq("midreset_idle", 64'(busy), 0);
        run(2'b00, 960, 896, 1'b0, 1'b1);
        do_reset();
        check_eq("err_cleared", 64'(err), 0);

        // Stray butterfly result while idle.
        @(posedge clk);
        #1;
        inj = 1'b1;
        check_eq("idle_inj_wr_en", 64'(wr_en), 0);
        check_eq("idle_inj_err_before", 64'(err), 0);
        @(posedge clk);
        #1;
        inj = 1'b0;
        check_eq("idle_inj_err", 64'(err), 1);
        repeat (5) @(posedge clk);
        #1;
        check_eq("idle_inj_err_sticky", 64'(err), 1);
        do_reset();
        check_eq("idle_inj_err_reset", 64'(err), 0);

`ifdef NTT_CTRL_PWM_EN
        run(2'b10, 138, 128, 1'b0, 1'b0);
`else
        @(posedge clk);
        #1;
        mode = 2'b10;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("pwm_disabled_idle", 64'(busy), 0);
        end
        start = 1'b0;
`endif
        @(posedge clk);
        #1;
        mode = 2'b11;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("mode11_idle", 64'(busy), 0);
        end
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
